// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing constants and colour width shared by the sync generator and text stage
package vga_pkg;
  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;
  localparam int RGB_W         = 3;
endpackage

// File: rtl/vga_pix_tick.sv
// vga_pix_tick: one-clk pixel strobe every TICK_DIV system clocks, first strobe on the TICK_DIV-th edge after reset
module vga_pix_tick #(
  parameter int TICK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic p_tick
);
  localparam logic [3:0] LAST = 4'(TICK_DIV - 1);
  logic [3:0] cnt;
  // Free-running divider; the strobe is registered so it rises on the edge that completes a pixel period
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt    <= '0;
      p_tick <= 1'b0;
    end else begin
      cnt    <= (cnt == LAST) ? 4'd0 : cnt + 4'd1;
      p_tick <= (cnt == LAST);
    end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA counters, registered active-low syncs and blanked colour; optional frame counter via VGA_SYNC_FRAME_CNT_EN
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter int TICK_DIV  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             p_tick,
  output logic [9:0]       pixel_x,
  output logic [9:0]       pixel_y,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [7:0]       frame_cnt
`endif
);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] H_LAST   = 10'(H_DISPLAY + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_DISPLAY + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FP + V_SYNC - 1);
  logic x_last, y_last, hs_next, vs_next;
  vga_pix_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .p_tick  (p_tick)
  );
  // Visible-area decode and next sync levels from the current counter position
  always_comb begin
    video_on = (pixel_x < H_VIS) && (pixel_y < V_VIS);
    x_last   = (pixel_x == H_LAST);
    y_last   = (pixel_y == V_LAST);
    hs_next  = !((pixel_x >= HS_START) && (pixel_x <= HS_END));
    vs_next  = !((pixel_y >= VS_START) && (pixel_y <= VS_END));
  end
  // Pixel and line counters advance only on the pixel strobe
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (p_tick) begin
      pixel_x <= x_last ? 10'd0 : pixel_x + 10'd1;
      if (x_last) pixel_y <= y_last ? 10'd0 : pixel_y + 10'd1;
    end
  // Syncs and colour registered together so they reach the DAC one pixel behind the counters
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= '0;
    end else if (p_tick) begin
      hsync <= hs_next;
      vsync <= vs_next;
      rgb   <= video_on ? rgb_in : '0;
    end
`ifdef VGA_SYNC_FRAME_CNT_EN
  // Frame counter bumps on the edge where the line counter wraps to 0
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) frame_cnt <= '0;
    else if (p_tick && x_last && y_last) frame_cnt <= frame_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of a default-timing instance and a tiny-timing instance for whole-frame behaviour
module tb_vga_sync_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0_n, rst1_n;
  logic [2:0] rgb_in0 = 3'b101, rgb_in1 = 3'b101;
  logic tick0, tick1, von0, von1, hs0, hs1, vs0, vs1;
  logic [9:0] x0, y0, x1, y1;
  logic [2:0] rgb0, rgb1;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] fc0, fc1;
`endif
  vga_sync_gen u0 (
    .clk(clk), .reset_n(rst0_n), .rgb_in(rgb_in0), .p_tick(tick0), .pixel_x(x0), .pixel_y(y0),
    .video_on(von0), .hsync(hs0), .vsync(vs0), .rgb(rgb0)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .frame_cnt(fc0)
`endif
  );
  // 16 pixels x 12 lines, one clk per pixel: sync at x 10..12, vsync at y 8..9, 192-clk frame
  vga_sync_gen #(
    .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_DISPLAY(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .TICK_DIV(1)
  ) u1 (
    .clk(clk), .reset_n(rst1_n), .rgb_in(rgb_in1), .p_tick(tick1), .pixel_x(x1), .pixel_y(y1),
    .video_on(von1), .hsync(hs1), .vsync(vs1), .rgb(rgb1)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .frame_cnt(fc1)
`endif
  );
  int n_tests = 0, n_fail = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  typedef struct {
    int k;
    int x;
    int y;
    int hs;
    int vs;
    int tick;
    int rgb;
  } vec_t;
  vec_t tv[14];
  int edges;
  initial begin
    // k = rising edges since release; pixel advances happen on edges 3,5,7,...
    tv[0]  = '{0,    0,   0, 1, 1, 0, 0};
    tv[1]  = '{1,    0,   0, 1, 1, 0, 0};
    tv[2]  = '{2,    0,   0, 1, 1, 1, 0};
    tv[3]  = '{3,    1,   0, 1, 1, 0, 5};
    tv[4]  = '{4,    1,   0, 1, 1, 1, 5};
    tv[5]  = '{1281, 640, 0, 1, 1, 0, 5};
    tv[6]  = '{1283, 641, 0, 1, 1, 0, 0};
    tv[7]  = '{1313, 656, 0, 1, 1, 0, 0};
    tv[8]  = '{1315, 657, 0, 0, 1, 0, 0};
    tv[9]  = '{1505, 752, 0, 0, 1, 0, 0};
    tv[10] = '{1507, 753, 0, 1, 1, 0, 0};
    tv[11] = '{1599, 799, 0, 1, 1, 0, 0};
    tv[12] = '{1601, 0,   1, 1, 1, 0, 0};
    tv[13] = '{1603, 1,   1, 1, 1, 0, 5};
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_x", int'(x0), 0);
    chk("rst_hs", int'(hs0), 1);
    chk("rst_tick", int'(tick0), 0);
    rst0_n = 1'b1;
    edges = 0;
    for (int i = 0; i < 14; i++) begin
      while (edges < tv[i].k) begin
        @(negedge clk);
        edges++;
      end
      chk($sformatf("k%0d_x", tv[i].k), int'(x0), tv[i].x);
      chk($sformatf("k%0d_y", tv[i].k), int'(y0), tv[i].y);
      chk($sformatf("k%0d_hs", tv[i].k), int'(hs0), tv[i].hs);
      chk($sformatf("k%0d_vs", tv[i].k), int'(vs0), tv[i].vs);
      chk($sformatf("k%0d_tick", tv[i].k), int'(tick0), tv[i].tick);
      chk($sformatf("k%0d_rgb", tv[i].k), int'(rgb0), tv[i].rgb);
    end
    // Mid-line asynchronous reset at pixel (300,1)
    while (edges < 2201) begin
      @(negedge clk);
      edges++;
    end
    chk("pre_rst_x", int'(x0), 300);
    chk("pre_rst_y", int'(y0), 1);
    #2 rst0_n = 1'b0;
    #1;
    chk("async_x", int'(x0), 0);
    chk("async_y", int'(y0), 0);
    chk("async_hs", int'(hs0), 1);
    chk("async_vs", int'(vs0), 1);
    chk("async_rgb", int'(rgb0), 0);
    chk("async_tick", int'(tick0), 0);
    repeat (3) @(negedge clk);
    rst0_n = 1'b1;
    @(negedge clk);
    chk("rel_e1_tick", int'(tick0), 0);
    @(negedge clk);
    chk("rel_e2_tick", int'(tick0), 1);
    chk("rel_e2_x", int'(x0), 0);
    @(negedge clk);
    chk("rel_e3_x", int'(x0), 1);
    // One line of hsync: 192 low clks, 96 of them with the strobe high
    begin
      int hs_clks = 0, hs_ticks = 0;
      for (int k = 4; k <= 1610; k++) begin
        @(negedge clk);
        if (!hs0) hs_clks++;
        if (!hs0 && tick0) hs_ticks++;
      end
      chk("hs_low_clks", hs_clks, 192);
      chk("hs_low_ticks", hs_ticks, 96);
    end
    // Tiny instance: frame period, vsync width, blanked colour, frame counter
    rst1_n = 1'b1;
    begin
      int wraps = 0, first_wrap = 0, period = 0, vs_clks = 0, rgb_clks = 0;
      logic [9:0] prev_y;
`ifdef VGA_SYNC_FRAME_CNT_EN
      chk("fc_reset", int'(fc1), 0);
`endif
      prev_y = y1;
      for (int k = 1; k <= 1000; k++) begin
        @(negedge clk);
        if (prev_y == 10'd11 && y1 == 10'd0) begin
          wraps++;
          if (wraps == 1) first_wrap = k;
          if (wraps == 2) period = k - first_wrap;
`ifdef VGA_SYNC_FRAME_CNT_EN
          if (wraps <= 3) chk($sformatf("fc_wrap%0d", wraps), int'(fc1), wraps);
          if (wraps == 4) chk("fc_wrap_255", int'(fc1), 0);
          if (wraps == 3) begin
            force u1.frame_cnt = 8'd255;
            #1 release u1.frame_cnt;
          end
`endif
        end
        if (wraps == 1) begin
          if (!vs1) vs_clks++;
          if (rgb1 != 3'b000) rgb_clks++;
        end
        prev_y = y1;
      end
      chk("frame_wraps_seen", int'(wraps >= 4), 1);
      chk("frame_period", period, 192);
      chk("vs_low_clks", vs_clks, 32);
      chk("rgb_visible_clks", rgb_clks, 48);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_DISPLAY, 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48, giving horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL have parameters V_DISPLAY 480, V_FP 10, V_SYNC 2, V_BP 33, giving vertical visible lines, front porch, sync and back porch in lines.
REQ-004 SHALL have parameter TICK_DIV, 2, system clocks per pixel (legal range 1..16).
REQ-005 SHALL have port clk, input, 1, single system clock (50 MHz nominal); all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rgb_in, input, 3, pixel colour from the text/graphics stage for the current pixel_x/pixel_y.
REQ-008 SHALL have port p_tick, output, 1, one-clk pixel strobe.
REQ-009 SHALL have ports pixel_x and pixel_y, output, 10 each, current horizontal and vertical counters.
REQ-010 SHALL have port video_on, output, 1, combinational, high while pixel_x<H_DISPLAY and pixel_y<V_DISPLAY.
REQ-011 SHALL have ports hsync and vsync, output, 1 each, registered, active-low sync pulses.
REQ-012 SHALL have port rgb, output, 3, registered colour to the DAC pins.

Function
REQ-013 SHALL generate p_tick high for exactly one clk in every TICK_DIV clks; the first p_tick falls on the TICK_DIV-th rising edge after reset_n deasserts. With TICK_DIV=1, p_tick is constantly high.
REQ-014 SHALL advance pixel_x only on clock edges where p_tick is high; it counts 0..H_TOTAL-1 (800) and wraps to 0.
REQ-015 SHALL increment pixel_y only on the edge where pixel_x wraps; it counts 0..V_TOTAL-1 (525) and wraps to 0 on that same edge.
REQ-016 SHALL compute the next hsync on each p_tick as low iff pixel_x is in [656,751] (H_DISPLAY+H_FP .. +H_SYNC-1), i.e. registered one pixel behind the counter.
REQ-017 SHALL compute the next vsync on each p_tick as low iff pixel_y is in [490,491], with the same one-pixel delay.
REQ-018 SHALL register rgb on each p_tick: rgb_in when video_on is high, otherwise 3'b000, so rgb is aligned with hsync/vsync.
REQ-019 SHALL hold hsync, vsync, rgb and the counters unchanged between p_ticks.
REQ-020 SHALL make every counter width and comparison 10-bit unsigned; H_TOTAL and V_TOTAL SHALL be derived as sums of the parameters and SHALL NOT be separate parameters.
REQ-021 SHALL produce frame length H_TOTAL*V_TOTAL*TICK_DIV clks (840000 at defaults).

Reset
REQ-022 SHALL, while reset_n is low, force asynchronously: divider to 0, p_tick 0, pixel_x 0, pixel_y 0, hsync 1, vsync 1, rgb 3'b000.
REQ-023 SHALL, when reset occurs mid-frame, take effect immediately with no completion of the current line; timing restarts from pixel (0,0) after release.

Configuration
REQ-024 SHALL, when VGA_SYNC_FRAME_CNT_EN is defined, add output frame_cnt[7:0]. It resets to 0 and increments on the edge where pixel_y wraps 524->0. It wraps 255->0.
REQ-025 SHALL, when VGA_SYNC_FRAME_CNT_EN is undefined, omit the frame_cnt port and its logic entirely, with all other behaviour identical.

Structure
REQ-026 SHALL place the default timing constants (640/16/96/48, 480/10/2/33) and the rgb width in shared package vga_pkg, also used by the text stage.
REQ-027 SHALL implement the pixel-tick divider as sub-module vga_pix_tick (ports clk, reset_n, p_tick; parameter TICK_DIV).

Verification
REQ-028 SHALL verify: release reset, TICK_DIV=2 -> p_tick at clk 2,4,6...; pixel_x steps 0..799 then 0, with pixel_y incrementing 0->1 on that edge.
REQ-029 SHALL verify: run one line -> hsync low for exactly 96 pixel ticks (192 clks), first low tick one pixel after pixel_x=656.
REQ-030 SHALL verify: run full frame -> vsync low for exactly 2 lines (1600 ticks) after pixel_y 490/491; frame period 840000 clks; pixel_y wraps 524->0.
REQ-031 SHALL verify: rgb_in=3'b101 held -> rgb=3'b101 for pixels sampled at x<640, and rgb=3'b000 for the pixel sampled at x=640 and for all pixels at y>=480.
REQ-032 SHALL verify: reset_n pulsed low at pixel (300,200) -> same-edge-independent clear to counters 0, hsync=vsync=1, rgb=0; first p_tick 2 clks after release.
REQ-033 SHALL verify: with VGA_SYNC_FRAME_CNT_EN, run 3 frames -> frame_cnt 0,1,2,3 at each wrap; with frame_cnt preloaded by forcing 255 -> wraps to 0.
